pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 4, total EX-stage occupancy of a divide op in cycles (legal 2..15).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 IDEX_MemRead  in  1  instruction in ID/EX is a load.
REQ-005 IDEX_RegRD  in  4  destination register of the ID/EX instruction.
REQ-006 IFID_RegRS, IFID_RegRT  in  4 each  source registers of the IF/ID instruction.
REQ-007 IFID_UsesRS, IFID_UsesRT  in  1 each  the IF/ID instruction reads that source.
REQ-008 branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-009 div_start  in  1  ID/EX holds a divide or remainder op this cycle.
REQ-010 halt  in  1  halt request.
REQ-011 PC_Write, IFID_Write  out  1 each  enable PC and IF/ID update.
REQ-012 FLUSH_IF, FLUSH_ID, FLUSH_EX  out  1 each  bubble insert into IF/ID, ID/EX, EX/M buffers.
REQ-013 EX_Stall  out  1  hold the ID/EX buffer.
REQ-014 div_done  out  1  ALU_Result and ALU_Remainder are valid for EX/M capture this cycle.
REQ-015 ctrl_state  out  2  current FSM state.

Function
REQ-016 FSM states SHALL be RUN=00, LOAD_STALL=01, DIV_WAIT=10, HALTED=11; state and counter registered, outputs combinational from state, counter and inputs.
REQ-017 RUN defaults SHALL be PC_Write=1, IFID_Write=1, all FLUSH=0, EX_Stall=0, div_done=0.
REQ-018 RUN priority SHALL be halt > branch_taken > div_start > load-use.
REQ-019 Load-use SHALL be IDEX_MemRead=1, IDEX_RegRD nonzero, and matching (IFID_RegRS with IFID_UsesRS) or (IFID_RegRT with IFID_UsesRT).
REQ-020 On load-use in RUN: PC_Write=0, IFID_Write=0, FLUSH_ID=1 that cycle; next state LOAD_STALL.
REQ-021 LOAD_STALL SHALL output RUN defaults and return to RUN next cycle, giving exactly one bubble.
REQ-022 branch_taken in RUN SHALL assert FLUSH_IF=1 and FLUSH_ID=1 for that cycle only, with PC_Write=1; state stays RUN.
REQ-023 div_start in RUN SHALL assert EX_Stall=1, FLUSH_EX=1, PC_Write=0, IFID_Write=0, load counter with DIV_CYCLES-2, and enter DIV_WAIT.
REQ-024 DIV_WAIT with counter>0 SHALL hold the same stall outputs and decrement the counter.
REQ-025 DIV_WAIT with counter=0 SHALL assert div_done=1, release the stall (RUN defaults), and go to RUN. Total stall is DIV_CYCLES-1 cycles.
REQ-026 branch_taken, div_start and load-use SHALL be ignored in DIV_WAIT, LOAD_STALL and HALTED.
REQ-027 halt in RUN or LOAD_STALL SHALL enter HALTED next cycle.
REQ-028 halt in DIV_WAIT SHALL be latched and take effect on the div_done cycle: next state HALTED instead of RUN.
REQ-029 HALTED SHALL output PC_Write=0, IFID_Write=0, FLUSH_ID=1, others 0, and persist until reset.

Reset
REQ-030 While rst_n=0: state=RUN, counter=0, pending-halt=0.
REQ-031 While rst_n=0, outputs SHALL be forced to PC_Write=0, IFID_Write=0, FLUSH_IF=FLUSH_ID=FLUSH_EX=1, EX_Stall=0, div_done=0, ctrl_state=00.
REQ-032 Reset assertion mid-DIV_WAIT SHALL abort the divide immediately. The first cycle after release SHALL show RUN defaults.

Configuration
REQ-033 Macro MULTICYCLE_DIV_EN defined: divide sequencing per REQ-023..025 and REQ-028.
REQ-034 Macro undefined: div_start ignored, DIV_WAIT unreachable, no counter logic, div_done tied 0, DIV_CYCLES unused.

Structure
REQ-035 State encodings and the 2-bit state width SHALL live in shared package pipe_ctrl_pkg.
REQ-036 The divide countdown SHALL be sub-module stall_counter (4-bit, load/decrement/zero flag), instantiated only under MULTICYCLE_DIV_EN.

Verification
REQ-037 Reset held 3 cycles -> all FLUSH=1, PC_Write=0. Release -> next cycle PC_Write=1, FLUSH=0, ctrl_state=00.
REQ-038 IDEX_MemRead=1, IDEX_RegRD=5, IFID_RegRS=5, IFID_UsesRS=1 -> one cycle PC_Write=0, FLUSH_ID=1, then LOAD_STALL, then RUN.
REQ-039 Same as REQ-038 with IFID_UsesRS=0 or IDEX_RegRD=0 -> no stall.
REQ-040 DIV_CYCLES=4, div_start pulse -> EX_Stall=1 and FLUSH_EX=1 for 3 cycles, then div_done=1 for 1 cycle, then RUN.
REQ-041 branch_taken and div_start in the same RUN cycle -> FLUSH_IF=FLUSH_ID=1, no stall, state stays 00.
REQ-042 halt raised during DIV_WAIT (DIV_CYCLES=4) -> div_done occurs on schedule, then ctrl_state=11 with PC_Write=0 until rst_n=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: state width,
//   FSM state encodings and the load-use hazard predicate.
//   Optional feature macro used by the consumers: MULTICYCLE_DIV_EN.
package pipe_ctrl_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      DIV_WAIT   = 2'b10,
      HALTED     = 2'b11
   } ctrlState_t;

   // A load in ID/EX feeds a source that the IF/ID instruction actually reads.
   // Register 0 is hard-wired, so it never creates a dependency.
   function automatic logic loadUseHazard(
      input logic       memRead,
      input logic [3:0] regRd,
      input logic [3:0] regRs,
      input logic [3:0] regRt,
      input logic       usesRs,
      input logic       usesRt
   );
      return memRead && (regRd != '0) &&
             ((usesRs && (regRs == regRd)) || (usesRt && (regRt == regRd)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_stall_counter.sv
// stall_counter
//   4-bit down-counter used to time the divide occupancy of EX.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset (count -> 0)
//     load        - load loadVal (takes priority over dec)
//     loadVal     - value to load
//     dec         - decrement by one (saturates at zero)
//     isZero      - count is zero
module stall_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] loadVal,
   input  logic       dec,
   output logic       isZero
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= loadVal;
      end else if (dec && (count != '0)) begin
         count <= count - 4'd1;
      end
   end

   assign isZero = (count == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard/stall controller for a 5-stage pipeline: load-use bubbles,
//   taken-branch flushes, multi-cycle divide stall and halt.
//   Optional feature: MULTICYCLE_DIV_EN enables divide sequencing; when
//   undefined div_start is ignored, DIV_WAIT is unreachable, div_done is 0.
//   Ports:
//     clk, rst_n                  - clock, asynchronous active-low reset
//     IDEX_MemRead, IDEX_RegRD    - ID/EX load flag and destination
//     IFID_RegRS/RT, IFID_UsesRS/RT - IF/ID sources and their use flags
//     branch_taken, div_start, halt - EX branch, divide start, halt request
//     PC_Write, IFID_Write        - PC / IF/ID update enables
//     FLUSH_IF/ID/EX              - bubble insert into IF/ID, ID/EX, EX/M
//     EX_Stall                    - hold ID/EX
//     div_done                    - divide result valid for EX/M capture
//     ctrl_state                  - current FSM state
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               IDEX_MemRead,
   input  logic [3:0]         IDEX_RegRD,
   input  logic [3:0]         IFID_RegRS,
   input  logic [3:0]         IFID_RegRT,
   input  logic               IFID_UsesRS,
   input  logic               IFID_UsesRT,
   input  logic               branch_taken,
   input  logic               div_start,
   input  logic               halt,
   output logic               PC_Write,
   output logic               IFID_Write,
   output logic               FLUSH_IF,
   output logic               FLUSH_ID,
   output logic               FLUSH_EX,
   output logic               EX_Stall,
   output logic               div_done,
   output logic [STATE_W-1:0] ctrl_state
);

   if (DIV_CYCLES < 2 || DIV_CYCLES > 15) begin : gBadDivCycles
      $error("pipe_hazard_ctrl: DIV_CYCLES must be in 2..15");
   end

   ctrlState_t state, nextState;
   logic       loadUse;

   assign loadUse = loadUseHazard(IDEX_MemRead, IDEX_RegRD, IFID_RegRS,
                                  IFID_RegRT, IFID_UsesRS, IFID_UsesRT);

`ifdef MULTICYCLE_DIV_EN
   localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 2);

   logic cntLoad, cntDec, cntZero;
   logic pendHalt, nextPendHalt;

   stall_counter uCounter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (cntLoad),
      .loadVal (DivLoad),
      .dec     (cntDec),
      .isZero  (cntZero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pendHalt <= 1'b0;
      else        pendHalt <= nextPendHalt;
   end
`else
   // Divide sequencing is compiled out; the input is deliberately dropped.
   logic unusedDivStart;
   assign unusedDivStart = div_start;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= nextState;
   end

   always_comb begin
      PC_Write   = 1'b1;
      IFID_Write = 1'b1;
      FLUSH_IF   = 1'b0;
      FLUSH_ID   = 1'b0;
      FLUSH_EX   = 1'b0;
      EX_Stall   = 1'b0;
      div_done   = 1'b0;
      nextState  = state;
`ifdef MULTICYCLE_DIV_EN
      cntLoad      = 1'b0;
      cntDec       = 1'b0;
      nextPendHalt = pendHalt;
`endif
      unique case (state)
         RUN: begin
            if (halt) begin
               nextState = HALTED;
            end else if (branch_taken) begin
               FLUSH_IF = 1'b1;
               FLUSH_ID = 1'b1;
`ifdef MULTICYCLE_DIV_EN
            end else if (div_start) begin
               PC_Write     = 1'b0;
               IFID_Write   = 1'b0;
               EX_Stall     = 1'b1;
               FLUSH_EX     = 1'b1;
               cntLoad      = 1'b1;
               nextPendHalt = 1'b0;
               nextState    = DIV_WAIT;
`endif
            end else if (loadUse) begin
               PC_Write   = 1'b0;
               IFID_Write = 1'b0;
               FLUSH_ID   = 1'b1;
               nextState  = LOAD_STALL;
            end
         end
         LOAD_STALL: begin
            nextState = halt ? HALTED : RUN;
         end
         DIV_WAIT: begin
`ifdef MULTICYCLE_DIV_EN
            // A halt seen at any point in the wait, including the final
            // cycle, redirects the exit from RUN to HALTED.
            if (!cntZero) begin
               PC_Write   = 1'b0;
               IFID_Write = 1'b0;
               EX_Stall   = 1'b1;
               FLUSH_EX   = 1'b1;
               cntDec     = 1'b1;
               if (halt) nextPendHalt = 1'b1;
            end else begin
               div_done     = 1'b1;
               nextState    = (pendHalt || halt) ? HALTED : RUN;
               nextPendHalt = 1'b0;
            end
`else
            nextState = RUN;
`endif
         end
         HALTED: begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            FLUSH_ID   = 1'b1;
         end
         default: nextState = RUN;
      endcase

      if (!rst_n) begin
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
         FLUSH_IF   = 1'b1;
         FLUSH_ID   = 1'b1;
         FLUSH_EX   = 1'b1;
         EX_Stall   = 1'b0;
         div_done   = 1'b0;
      end
   end

   assign ctrl_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
//   randomized stimulus, all compared against a cycle-level reference model.
//   Honors MULTICYCLE_DIV_EN the same way as the design.
module tb_pipe_hazard_ctrl;

   localparam int unsigned DivCycles = 4;
`ifdef MULTICYCLE_DIV_EN
   localparam bit DivEn = 1'b1;
`else
   localparam bit DivEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       IDEX_MemRead = 1'b0;
   logic [3:0] IDEX_RegRD = '0;
   logic [3:0] IFID_RegRS = '0;
   logic [3:0] IFID_RegRT = '0;
   logic       IFID_UsesRS = 1'b0;
   logic       IFID_UsesRT = 1'b0;
   logic       branch_taken = 1'b0;
   logic       div_start = 1'b0;
   logic       halt = 1'b0;
   logic       PC_Write, IFID_Write, FLUSH_IF, FLUSH_ID, FLUSH_EX;
   logic       EX_Stall, div_done;
   logic [1:0] ctrl_state;

   pipe_hazard_ctrl #(.DIV_CYCLES(DivCycles)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .IDEX_MemRead (IDEX_MemRead),
      .IDEX_RegRD   (IDEX_RegRD),
      .IFID_RegRS   (IFID_RegRS),
      .IFID_RegRT   (IFID_RegRT),
      .IFID_UsesRS  (IFID_UsesRS),
      .IFID_UsesRT  (IFID_UsesRT),
      .branch_taken (branch_taken),
      .div_start    (div_start),
      .halt         (halt),
      .PC_Write     (PC_Write),
      .IFID_Write   (IFID_Write),
      .FLUSH_IF     (FLUSH_IF),
      .FLUSH_ID     (FLUSH_ID),
      .FLUSH_EX     (FLUSH_EX),
      .EX_Stall     (EX_Stall),
      .div_done     (div_done),
      .ctrl_state   (ctrl_state)
   );

   always #5 clk = ~clk;

   int checksRun = 0;
   int checksPassed = 0;
   int cyc = 0;

   // Reference model: mode 0=run 1=one bubble pending 2=dividing 3=halted.
   // Divide progress is measured as cycles elapsed since the start cycle.
   int mMode = 0;
   int mDivStartCyc = 0;
   bit mPendHalt = 1'b0;

   task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checksRun++;
      if (obs === exp) checksPassed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Output vector order: {PC_Write, IFID_Write, FLUSH_IF, FLUSH_ID, FLUSH_EX, EX_Stall, div_done}
   task automatic runCycle(input logic r, input logic mr, input logic [3:0] rd,
                           input logic [3:0] rs, input logic [3:0] rt,
                           input logic urs, input logic urt,
                           input logic br, input logic ds, input logic h);
      logic [6:0] e;
      logic [1:0] eState;
      int nm, nds, elapsed;
      bit np, lu;
      rst_n = r; IDEX_MemRead = mr; IDEX_RegRD = rd; IFID_RegRS = rs; IFID_RegRT = rt;
      IFID_UsesRS = urs; IFID_UsesRT = urt; branch_taken = br; div_start = ds; halt = h;
      @(negedge clk);
      nm = mMode; nds = mDivStartCyc; np = mPendHalt;
      lu = mr && (rd != 4'd0) && ((urs && rs == rd) || (urt && rt == rd));
      e = 7'b1100000;
      eState = 2'(mMode);
      if (!r) begin
         e = 7'b0011100; eState = 2'd0; nm = 0; np = 1'b0;
      end else begin
         case (mMode)
            0: begin
               if (h) nm = 3;
               else if (br) e = 7'b1111000;
               else if (DivEn && ds) begin
                  e = 7'b0000110; nm = 2; nds = cyc; np = 1'b0;
               end else if (lu) begin
                  e = 7'b0001000; nm = 1;
               end
            end
            1: nm = h ? 3 : 0;
            2: begin
               np = mPendHalt | h;
               elapsed = cyc - mDivStartCyc;
               if (elapsed < int'(DivCycles) - 1) e = 7'b0000110;
               else begin
                  e = 7'b1100001; nm = np ? 3 : 0; np = 1'b0;
               end
            end
            default: e = 7'b0001000;
         endcase
      end
      checkVal("outputs", {1'b0, PC_Write, IFID_Write, FLUSH_IF, FLUSH_ID, FLUSH_EX, EX_Stall, div_done},
               {1'b0, e});
      checkVal("ctrl_state", {6'd0, ctrl_state}, {6'd0, eState});
      @(posedge clk);
      mMode = nm; mDivStartCyc = nds; mPendHalt = np;
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) runCycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic       r, mr, urs, urt, br, ds, h;
      logic [3:0] rd, rs, rt;

      // reset held, then release
      for (int i = 0; i < 3; i++) runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // load-use on RS, then the non-stalling variants
      runCycle(1, 1, 4'd5, 4'd5, 4'd0, 1, 0, 0, 0, 0);
      idle(2);
      runCycle(1, 1, 4'd5, 4'd5, 4'd0, 0, 0, 0, 0, 0);
      runCycle(1, 1, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, 0);
      runCycle(1, 1, 4'd7, 4'd1, 4'd7, 0, 1, 0, 0, 0);
      idle(2);
      // divide pulse
      runCycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(5);
      // branch and divide together
      runCycle(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      idle(2);
      // reset in the middle of a divide
      runCycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      runCycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      // halt during divide wait
      runCycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      runCycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(5);
      runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      for (int i = 0; i < 3000; i++) begin
         r   = (mMode == 3) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) != 0);
         mr  = 1'($urandom_range(0, 1));
         rd  = 4'($urandom_range(0, 3));
         rs  = 4'($urandom_range(0, 3));
         rt  = 4'($urandom_range(0, 3));
         urs = 1'($urandom_range(0, 1));
         urt = 1'($urandom_range(0, 1));
         br  = ($urandom_range(0, 7) == 0);
         ds  = ($urandom_range(0, 9) == 0);
         h   = ($urandom_range(0, 63) == 0);
         runCycle(r, mr, rd, rs, rt, urs, urt, br, ds, h);
      end

      $display("%0d/%0d checks passed", checksPassed, checksRun);
      $finish;
   end

endmodule
